// File: rtl/sram_like_bridge.sv
// sram_like_bridge: merges the IF and MEM sram-like channels onto one shared sram-like bus.
// Keeps up to MAX_OUT requests in flight. Responses come back in order to the owning
// channel. Instruction responses cancelled by a pipeline flush are dropped.
// Optional feature macro: SRAM_BRIDGE_PERF_EN enables the perf counters. When it is
// undefined, the counter outputs are tied to zero.
module sram_like_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                inst_req,
  input  logic                inst_wr,
  input  logic [1:0]          inst_size,
  input  logic [DATA_W/8-1:0] inst_wstrb,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic [DATA_W-1:0]   inst_wdata,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                bus_req,
  output logic                bus_wr,
  output logic [1:0]          bus_size,
  output logic [DATA_W/8-1:0] bus_wstrb,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic                bus_addr_ok,
  input  logic                bus_data_ok,
  input  logic [DATA_W-1:0]   bus_rdata,
  output logic                proto_err,
  output logic [31:0]         perf_inst_cnt,
  output logic [31:0]         perf_data_cnt,
  output logic [31:0]         perf_stall_cnt
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned PTR_W  = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUT);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUT - 1);

  typedef enum logic [1:0] {StIdle, StHoldInst, StHoldData} state_e;

  state_e              state_q, state_d;
  logic                hold_wr_q;
  logic [1:0]          hold_size_q;
  logic [STRB_W-1:0]   hold_wstrb_q;
  logic [ADDR_W-1:0]   hold_addr_q;
  logic [DATA_W-1:0]   hold_wdata_q;
  logic                hold_cancel_q, hold_cancel_d;
  logic                latch_en;

  // Tag FIFO: owner (1 = data channel) and cancel flag per in-flight request
  logic                tag_data_q   [MAX_OUT];
  logic                tag_cancel_q [MAX_OUT];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic                push, push_data, push_cancel, pop;
  logic                grant_any;
  logic                proto_err_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Arbitration, bus mux, handshake outputs and FIFO push decision
  always_comb begin
    state_d       = state_q;
    hold_cancel_d = hold_cancel_q;
    latch_en      = 1'b0;
    push          = 1'b0;
    push_data     = 1'b0;
    push_cancel   = 1'b0;
    inst_addr_ok  = 1'b0;
    data_addr_ok  = 1'b0;
    grant_any     = 1'b0;
    bus_req       = 1'b0;
    bus_wr        = data_req ? data_wr    : inst_wr;
    bus_size      = data_req ? data_size  : inst_size;
    bus_wstrb     = data_req ? data_wstrb : inst_wstrb;
    bus_addr      = data_req ? data_addr  : inst_addr;
    bus_wdata     = data_req ? data_wdata : inst_wdata;
    case (state_q)
      StIdle: begin
        // Data has fixed priority; inst is never granted in a flush cycle
        grant_any = data_req | (inst_req & ~flush);
        bus_req   = grant_any & (count_q < MAX_CNT);
        if (bus_req) begin
          if (bus_addr_ok) begin
            push         = 1'b1;
            push_data    = data_req;
            data_addr_ok = data_req;
            inst_addr_ok = ~data_req;
          end else begin
            latch_en      = 1'b1;
            hold_cancel_d = 1'b0;
            state_d       = data_req ? StHoldData : StHoldInst;
          end
        end
      end
      StHoldInst, StHoldData: begin
        bus_req   = 1'b1;
        bus_wr    = hold_wr_q;
        bus_size  = hold_size_q;
        bus_wstrb = hold_wstrb_q;
        bus_addr  = hold_addr_q;
        bus_wdata = hold_wdata_q;
        if (state_q == StHoldInst && flush) hold_cancel_d = 1'b1;
        if (bus_addr_ok) begin
          push    = 1'b1;
          state_d = StIdle;
          if (state_q == StHoldData) begin
            push_data    = 1'b1;
            data_addr_ok = 1'b1;
          end else begin
            // A request flushed while on the bus still completes, but its reply is dropped
            push_cancel  = hold_cancel_q | flush;
            inst_addr_ok = ~(hold_cancel_q | flush);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Response routing from the FIFO head
  always_comb begin
    pop          = bus_data_ok & (count_q != '0);
    data_data_ok = pop & tag_data_q[rd_ptr_q];
    inst_data_ok = pop & ~tag_data_q[rd_ptr_q] & ~tag_cancel_q[rd_ptr_q] & ~flush;
    inst_rdata   = bus_rdata;
    data_rdata   = bus_rdata;
  end

  // FSM state and latched request payload
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      hold_cancel_q <= 1'b0;
      hold_wr_q     <= 1'b0;
      hold_size_q   <= '0;
      hold_wstrb_q  <= '0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      hold_cancel_q <= hold_cancel_d;
      if (latch_en) begin
        hold_wr_q    <= bus_wr;
        hold_size_q  <= bus_size;
        hold_wstrb_q <= bus_wstrb;
        hold_addr_q  <= bus_addr;
        hold_wdata_q <= bus_wdata;
      end
    end
  end

  // Tag FIFO: flush marks in-flight inst tags, then push/pop update pointers and count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        tag_data_q[i]   <= 1'b0;
        tag_cancel_q[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < MAX_OUT; i++) begin
        if (flush && !tag_data_q[i]) tag_cancel_q[i] <= 1'b1;
      end
      if (push) begin
        tag_data_q[wr_ptr_q]   <= push_data;
        tag_cancel_q[wr_ptr_q] <= push_cancel;
        wr_ptr_q               <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky protocol error: a response arrived with nothing in flight
  always_ff @(posedge clk) begin
    if (rst) proto_err_q <= 1'b0;
    else if (bus_data_ok && count_q == '0) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;

`ifdef SRAM_BRIDGE_PERF_EN
  logic [31:0] perf_inst_q, perf_data_q, perf_stall_q;

  // Accepted-request and address-stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_inst_q  <= '0;
      perf_data_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push && !push_data) perf_inst_q <= perf_inst_q + 32'd1;
      if (push && push_data) perf_data_q <= perf_data_q + 32'd1;
      if (bus_req && !bus_addr_ok) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_inst_cnt  = perf_inst_q;
  assign perf_data_cnt  = perf_data_q;
  assign perf_stall_cnt = perf_stall_q;
`else
  assign perf_inst_cnt  = 32'd0;
  assign perf_data_cnt  = 32'd0;
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_sram_like_bridge.sv
// Testbench for sram_like_bridge: a vector table for single-cycle arbitration, hand-written
// sequences for hold, full-FIFO, ordering, flush and protocol-error cases, and a response
// scoreboard.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, bus_size;
  logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, proto_err;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [31:0] perf_inst_cnt, perf_data_cnt, perf_stall_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic is_data;
    logic cancel;
  } tag_t;
  tag_t sb[$];

  typedef struct {
    logic       ireq, dreq, dwr, fl, aok;
    logic       exp_breq, exp_iok, exp_dok;
    logic [1:0] exp_own;  // 0 none, 1 inst, 2 data
  } vec_t;
  vec_t vecs[7];

  sram_like_bridge #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .proto_err(proto_err),
    .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt),
    .perf_stall_cnt(perf_stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic d, input logic c);
    tag_t t;
    t.is_data = d;
    t.cancel  = c;
    sb.push_back(t);
  endtask

  task automatic sb_flush();
    foreach (sb[i]) if (!sb[i].is_data) sb[i].cancel = 1'b1;
  endtask

  // Scoreboard consumer: every driven response pops the oldest expected tag
  always @(negedge clk) begin
    tag_t t;
    logic exp_i, exp_d;
    if (!rst && bus_data_ok) begin
      exp_i = 1'b0;
      exp_d = 1'b0;
      if (sb.size() != 0) begin
        t     = sb.pop_front();
        exp_d = t.is_data;
        exp_i = !t.is_data && !t.cancel && !flush;
      end
      check("resp_inst_data_ok", {31'd0, inst_data_ok}, {31'd0, exp_i});
      check("resp_data_data_ok", {31'd0, data_data_ok}, {31'd0, exp_d});
      if (exp_i) check("resp_inst_rdata", inst_rdata, bus_rdata);
      if (exp_d) check("resp_data_rdata", data_rdata, bus_rdata);
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    inst_req = 0; data_req = 0; inst_wr = 0; data_wr = 0;
    flush = 0; bus_addr_ok = 0; bus_data_ok = 0;
  endtask

  task automatic respond(input logic [31:0] rd, input logic fl);
    bus_data_ok = 1; bus_rdata = rd; flush = fl;
    if (fl) sb_flush();
    @(negedge clk);
    nxt();
    bus_data_ok = 0; flush = 0;
  endtask

  // One accepted request on the chosen channel; the grant is checked the same cycle
  task automatic accept(input logic is_d, input logic [31:0] addr);
    if (is_d) begin data_req = 1; data_addr = addr; end
    else begin inst_req = 1; inst_addr = addr; end
    bus_addr_ok = 1;
    sb_push(is_d, 1'b0);
    @(negedge clk);
    check(is_d ? "acc_data_addr_ok" : "acc_inst_addr_ok",
          {31'd0, is_d ? data_addr_ok : inst_addr_ok}, 32'd1);
    check("acc_bus_addr", bus_addr, addr);
    nxt();
    clr();
  endtask

  initial begin
    logic [31:0] exp_a;
    logic [31:0] exp_w;
    int unsigned exp_perf;

    vecs[0] = '{0, 0, 0, 0, 1, 0, 0, 0, 2'd0};
    vecs[1] = '{1, 0, 0, 0, 1, 1, 1, 0, 2'd1};
    vecs[2] = '{0, 1, 0, 0, 1, 1, 0, 1, 2'd2};
    vecs[3] = '{0, 1, 1, 0, 1, 1, 0, 1, 2'd2};
    vecs[4] = '{1, 1, 0, 0, 1, 1, 0, 1, 2'd2};
    vecs[5] = '{1, 0, 0, 1, 1, 0, 0, 0, 2'd0};
    vecs[6] = '{1, 1, 1, 1, 1, 1, 0, 1, 2'd2};

    rst = 1; clr();
    inst_size = 2'd2; data_size = 2'd2; inst_wstrb = 4'hf; data_wstrb = 4'hf;
    inst_addr = 0; data_addr = 0; inst_wdata = 0; data_wdata = 0; bus_rdata = 0;
    nxt(); nxt();
    @(negedge clk);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    check("rst_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    check("rst_proto_err", {31'd0, proto_err}, 32'd0);
    check("rst_perf_inst", perf_inst_cnt, 32'd0);
    check("rst_perf_data", perf_data_cnt, 32'd0);
    check("rst_perf_stall", perf_stall_cnt, 32'd0);
    nxt();
    rst = 0;

    // Single-cycle arbitration vectors from an idle, empty bridge
    for (int i = 0; i < 7; i++) begin
      inst_req = vecs[i].ireq; data_req = vecs[i].dreq; data_wr = vecs[i].dwr;
      flush = vecs[i].fl; bus_addr_ok = vecs[i].aok;
      inst_addr = 32'h1000_0000 + 32'(i) * 16; data_addr = 32'h2000_0000 + 32'(i) * 16;
      inst_wdata = 32'ha0 + 32'(i); data_wdata = 32'hd0 + 32'(i);
      if (vecs[i].fl) sb_flush();
      if (vecs[i].exp_breq && vecs[i].aok) sb_push(vecs[i].exp_own == 2'd2, 1'b0);
      @(negedge clk);
      check($sformatf("v%0d_bus_req", i), {31'd0, bus_req}, {31'd0, vecs[i].exp_breq});
      check($sformatf("v%0d_inst_addr_ok", i), {31'd0, inst_addr_ok}, {31'd0, vecs[i].exp_iok});
      check($sformatf("v%0d_data_addr_ok", i), {31'd0, data_addr_ok}, {31'd0, vecs[i].exp_dok});
      if (vecs[i].exp_own != 2'd0) begin
        exp_a = (vecs[i].exp_own == 2'd2) ? 32'h2000_0000 + 32'(i) * 16
                                          : 32'h1000_0000 + 32'(i) * 16;
        exp_w = (vecs[i].exp_own == 2'd2) ? 32'hd0 + 32'(i) : 32'ha0 + 32'(i);
        check($sformatf("v%0d_bus_addr", i), bus_addr, exp_a);
        check($sformatf("v%0d_bus_wdata", i), bus_wdata, exp_w);
        check($sformatf("v%0d_bus_wr", i), {31'd0, bus_wr},
              {31'd0, (vecs[i].exp_own == 2'd2) && vecs[i].dwr});
      end
      nxt();
      clr();
      if (vecs[i].exp_breq && vecs[i].aok) respond($urandom, 1'b0);
    end

    // Data request held on the bus; its payload must not follow the live inputs
    data_req = 1; data_addr = 32'h1c00_0000; bus_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin inst_req = 1; inst_addr = 32'h3000_0000; data_addr = 32'h2222_0000; end
      @(negedge clk);
      check($sformatf("hold%0d_bus_req", c), {31'd0, bus_req}, 32'd1);
      check($sformatf("hold%0d_bus_addr", c), bus_addr, 32'h1c00_0000);
      check($sformatf("hold%0d_addr_ok", c), {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      nxt();
    end
    bus_addr_ok = 1; sb_push(1'b1, 1'b0);
    @(negedge clk);
    check("hold_done_data_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd1);
    check("hold_done_bus_addr", bus_addr, 32'h1c00_0000);
    nxt();
    data_req = 0; sb_push(1'b0, 1'b0);
    @(negedge clk);
    check("after_hold_inst_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd2);
    check("after_hold_bus_addr", bus_addr, 32'h3000_0000);
    nxt(); clr();
    respond(32'h0000_00aa, 1'b0);
    respond(32'h0000_00bb, 1'b0);

    // Full FIFO blocks new requests; a pop does not bypass in the same cycle
    accept(1'b0, 32'h4000_0000);
    accept(1'b0, 32'h4000_0004);
    inst_req = 1; inst_addr = 32'h4000_0008; bus_addr_ok = 1;
    @(negedge clk);
    check("full_bus_req", {31'd0, bus_req}, 32'd0);
    check("full_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd0);
    nxt();
    bus_data_ok = 1; bus_rdata = 32'h55;
    @(negedge clk);
    check("full_pop_bus_req", {31'd0, bus_req}, 32'd0);
    nxt();
    bus_data_ok = 0; sb_push(1'b0, 1'b0);
    @(negedge clk);
    check("freed_bus_req", {31'd0, bus_req}, 32'd1);
    check("freed_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    nxt(); clr();
    respond(32'h66, 1'b0);
    respond(32'h77, 1'b0);

    // In-order return to the owning channel
    accept(1'b0, 32'h5000_0000);
    accept(1'b1, 32'h5000_0100);
    respond(32'h11, 1'b0);
    accept(1'b0, 32'h5000_0004);
    respond(32'h22, 1'b0);
    respond(32'h33, 1'b0);

    // Flush cancels inst reads already in flight
    accept(1'b0, 32'h6000_0000);
    accept(1'b0, 32'h6000_0004);
    flush = 1; sb_flush();
    nxt(); clr();
    respond(32'hdeadbeef, 1'b0);
    respond(32'hdeadbeef, 1'b0);

    // Flush while an inst request is held: accepted on the bus, hidden from IF
    inst_req = 1; inst_addr = 32'h6100_0000; bus_addr_ok = 0;
    @(negedge clk);
    check("hinst_bus_req", {31'd0, bus_req}, 32'd1);
    nxt();
    flush = 1; sb_flush();
    @(negedge clk);
    check("hinst_fl_bus_addr", bus_addr, 32'h6100_0000);
    check("hinst_fl_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    nxt();
    flush = 0; bus_addr_ok = 1; sb_push(1'b0, 1'b1);
    @(negedge clk);
    check("hinst_acc_bus_req", {31'd0, bus_req}, 32'd1);
    check("hinst_acc_inst_ok", {31'd0, inst_addr_ok}, 32'd0);
    nxt(); clr();
    respond(32'h1111_2222, 1'b0);

    // Flush coincident with the response drops it; data responses ignore flush
    accept(1'b0, 32'h6200_0000);
    respond(32'h88, 1'b1);
    accept(1'b1, 32'h6300_0000);
    flush = 1; sb_flush();
    nxt(); clr();
    respond(32'h99, 1'b0);

    // Stray response with nothing in flight (also shows the FIFO drained to empty)
    @(negedge clk);
    check("pre_proto_err", {31'd0, proto_err}, 32'd0);
    nxt();
    respond(32'h1234, 1'b0);
    @(negedge clk);
    check("proto_err_set", {31'd0, proto_err}, 32'd1);
    nxt(); nxt();
    @(negedge clk);
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);
    nxt();
    rst = 1;
    nxt();
    rst = 0;
    @(negedge clk);
    check("proto_err_cleared", {31'd0, proto_err}, 32'd0);
    nxt();

    // Perf counters: five data requests, then an inst request stalled for two cycles
    for (int k = 0; k < 5; k++) begin
      accept(1'b1, 32'h7000_0000 + 32'(k) * 4);
      respond(32'h100 + 32'(k), 1'b0);
    end
`ifdef SRAM_BRIDGE_PERF_EN
    exp_perf = 5;
`else
    exp_perf = 0;
`endif
    @(negedge clk);
    check("perf_data_cnt", perf_data_cnt, exp_perf);
    check("perf_inst_cnt0", perf_inst_cnt, 32'd0);
    nxt();
    inst_req = 1; inst_addr = 32'h7100_0000; bus_addr_ok = 0;
    nxt(); nxt();
    bus_addr_ok = 1; sb_push(1'b0, 1'b0);
    nxt(); clr();
    respond(32'h200, 1'b0);
    @(negedge clk);
    check("perf_inst_cnt1", perf_inst_cnt, (exp_perf != 0) ? 32'd1 : 32'd0);
    check("perf_stall_cnt", perf_stall_cnt, (exp_perf != 0) ? 32'd2 : 32'd0);
    check("sb_empty_at_end", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
